// File: rtl/uart_pkg.sv
// uart_pkg: shared types, frame constants and baud-divider helper for uart_core.
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int STOP_BITS        = 1;
    localparam int MIN_CLKS_PER_BIT = 16;

    typedef enum logic [1:0] {
        UART_NORMAL   = 2'b00,
        UART_LOOPBACK = 2'b01,
        UART_ECHO     = 2'b10
    } uart_mode_e;

    // RX_BREAK parks the receiver after a framing error until the line idles high.
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // Rounded clock cycles per serial bit.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: input synchronizer, 8N1 receive FSM and mid-bit sampling counter.
// Emits the received byte with a one-cycle done strobe, or a one-cycle framing-error strobe.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 done,
    output logic                 ferr,
    output logic                 idle
);

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic                 sync1, sync2, rxd_q;
    logic                 fall, tick_half, tick_full;
    rx_state_e            state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;

    assign fall      = rxd_q & ~sync2;
    assign tick_half = (cnt == HALF_M1);
    assign tick_full = (cnt == FULL_M1);
    assign data      = shreg;
    assign idle      = (state == RX_IDLE);

    // Two-flop synchronizer plus one delay stage for falling-edge detection; idles high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            rxd_q <= 1'b1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            rxd_q <= sync2;
        end
    end

    // RX state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RX_IDLE;
        else      state <= state_nxt;
    end

    // RX next-state: half-bit check of the start bit, then full-bit steps to each centre.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RX_IDLE:  if (fall) state_nxt = RX_START;
            RX_START: if (tick_half) state_nxt = sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick_full && bit_idx == LAST_BIT) state_nxt = RX_STOP;
            RX_STOP:  if (tick_full) state_nxt = sync2 ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (sync2) state_nxt = RX_IDLE;
            default:  state_nxt = RX_IDLE;
        endcase
    end

    // Sampling counter, data shifter and result strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            done    <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            if (state == RX_IDLE || state == RX_BREAK || state_nxt != state || tick_full)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state == RX_IDLE)
                bit_idx <= '0;
            else if (state == RX_DATA && tick_full) begin
                bit_idx <= bit_idx + 1'b1;
                shreg   <= {sync2, shreg[DATA_BITS-1:1]};
            end
            done <= (state == RX_STOP) && tick_full && sync2;
            ferr <= (state == RX_STOP) && tick_full && !sync2;
        end
    end

endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex 8N1 UART with valid/ready byte streams.
// Holds the TX FSM, the one-deep RX holding register and the mode muxing.
// Optional feature macro: UART_LOOPBACK_EN enables loopback (01) and echo (10) modes;
// without it uart_mode is ignored and the core always runs in normal mode.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] uart_rd_data,
    output logic       uart_rd_valid,
    input  logic       uart_rd_ready,
    input  logic [7:0] uart_wr_data,
    input  logic       uart_wr_valid,
    output logic       uart_wr_ready,
    input  logic [1:0] uart_mode,
    input  logic       uart_rxd,
    output logic       uart_txd
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int CNT_W = $clog2(CLKS_PER_BIT * STOP_BITS + 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_M1  = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_baud
            $error("uart_core: CLKS_PER_BIT below minimum oversampling");
        end
    endgenerate

    logic                 rx_in, rx_done, rx_idle, echo;
    logic                 rx_ferr_unused;
    logic [DATA_BITS-1:0] rx_data;

    tx_state_e            tx_state, tx_state_nxt;
    logic [CNT_W-1:0]     tx_cnt;
    logic [BIT_W-1:0]     tx_bit;
    logic [DATA_BITS-1:0] tx_sh, tx_byte;
    logic                 tx_rdy, tx_go, tx_tick, stop_tick;

`ifdef UART_LOOPBACK_EN
    uart_mode_e mode_q;

    // Latch the requested mode only while both engines are idle; 11 falls back to normal.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mode_q <= UART_NORMAL;
        else if (rx_idle && tx_state == TX_IDLE)
            mode_q <= (uart_mode == 2'b11) ? UART_NORMAL : uart_mode_e'(uart_mode);
    end

    assign rx_in = (mode_q == UART_LOOPBACK) ? uart_txd : uart_rxd;
    assign echo  = (mode_q == UART_ECHO);
`else
    logic [2:0] mode_unused;
    assign mode_unused = {uart_mode, rx_idle};
    assign rx_in       = uart_rxd;
    assign echo        = 1'b0;
`endif

    // Framing errors simply drop the byte; no status is exported.
    uart_rx_engine #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rx_in),
        .data (rx_data),
        .done (rx_done),
        .ferr (rx_ferr_unused),
        .idle (rx_idle)
    );

    // One-deep RX holding register; a byte arriving while full is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uart_rd_data  <= '0;
            uart_rd_valid <= 1'b0;
        end else if (rx_done && !echo && (!uart_rd_valid || uart_rd_ready)) begin
            uart_rd_data  <= rx_data;
            uart_rd_valid <= 1'b1;
        end else if (uart_rd_valid && uart_rd_ready) begin
            uart_rd_valid <= 1'b0;
        end
    end

    // In echo mode the TX source is the receiver; the fabric write port is closed.
    assign tx_go         = echo ? (rx_done && tx_state == TX_IDLE) : (uart_wr_valid && tx_rdy);
    assign tx_byte       = echo ? rx_data : uart_wr_data;
    assign tx_tick       = (tx_cnt == FULL_M1);
    assign stop_tick     = (tx_cnt == STOP_M1);
    assign uart_wr_ready = tx_rdy && !echo;

    // TX state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_state <= TX_IDLE;
        else      tx_state <= tx_state_nxt;
    end

    // TX next-state: each bit lasts exactly one bit period.
    always_comb begin
        tx_state_nxt = tx_state;
        unique case (tx_state)
            TX_IDLE:  if (tx_go) tx_state_nxt = TX_START;
            TX_START: if (tx_tick) tx_state_nxt = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == LAST_BIT) tx_state_nxt = TX_STOP;
            TX_STOP:  if (stop_tick) tx_state_nxt = TX_IDLE;
            default:  tx_state_nxt = TX_IDLE;
        endcase
    end

    // TX datapath: registered line driver, bit counter and ready flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_rdy   <= 1'b0;
            uart_txd <= 1'b1;
        end else begin
            tx_rdy <= (tx_state_nxt == TX_IDLE);
            if (tx_state == TX_IDLE || tx_state_nxt != tx_state || (tx_state == TX_DATA && tx_tick))
                tx_cnt <= '0;
            else
                tx_cnt <= tx_cnt + 1'b1;
            unique case (tx_state)
                TX_IDLE: if (tx_go) begin
                    tx_sh    <= tx_byte;
                    tx_bit   <= '0;
                    uart_txd <= 1'b0;
                end
                TX_START: if (tx_tick) begin
                    uart_txd <= tx_sh[0];
                    tx_sh    <= tx_sh >> 1;
                end
                TX_DATA: if (tx_tick) begin
                    tx_bit <= tx_bit + 1'b1;
                    if (tx_bit == LAST_BIT) begin
                        uart_txd <= 1'b1;
                    end else begin
                        uart_txd <= tx_sh[0];
                        tx_sh    <= tx_sh >> 1;
                    end
                end
                default: uart_txd <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: scoreboard bench for uart_core (RX stream, TX framing, errors, modes, reset).
module tb_uart_core;

`ifdef UART_LOOPBACK_EN
    localparam int CLK_HZ = 50_000_000;
`else
    localparam int CLK_HZ = 100_000_000;
`endif
    localparam int BAUD = 115200;
    localparam int CPB  = (CLK_HZ + BAUD / 2) / BAUD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] uart_rd_data;
    logic       uart_rd_valid;
    logic       uart_rd_ready = 1'b1;
    logic [7:0] uart_wr_data = 8'h00;
    logic       uart_wr_valid = 1'b0;
    logic       uart_wr_ready;
    logic [1:0] uart_mode = 2'b00;
    logic       uart_rxd = 1'b1;
    logic       uart_txd;

    always #5 clk = ~clk;

    uart_core #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_rd_data  (uart_rd_data),
        .uart_rd_valid (uart_rd_valid),
        .uart_rd_ready (uart_rd_ready),
        .uart_wr_data  (uart_wr_data),
        .uart_wr_valid (uart_wr_valid),
        .uart_wr_ready (uart_wr_ready),
        .uart_mode     (uart_mode),
        .uart_rxd      (uart_rxd),
        .uart_txd      (uart_txd)
    );

    int         checks = 0;
    int         passes = 0;
    int         rx_cnt = 0;
    logic       seen_valid = 1'b0;
    logic [7:0] exp_q[$];
    logic       tx_exp_q[$];
    logic [7:0] mon_exp;

    // RX scoreboard: every read handshake pops one expected byte.
    always @(negedge clk) begin
        if (uart_rd_valid) seen_valid = 1'b1;
        if (uart_rd_valid && uart_rd_ready) begin
            rx_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL rx_scoreboard: got %02h, expected no byte", uart_rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (uart_rd_data !== mon_exp)
                    $display("FAIL rx_scoreboard: got %02h, expected %02h", uart_rd_data, mon_exp);
                else
                    passes++;
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    task automatic push_tx_bits(input logic [7:0] b);
        tx_exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_exp_q.push_back(b[i]);
        tx_exp_q.push_back(1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (uart_txd !== 1'b1) $display("FAIL reset_txd: got %b, expected 1", uart_txd); else passes++;
        checks++; if (uart_rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b, expected 0", uart_rd_valid); else passes++;
        checks++; if (uart_rd_data !== 8'h00) $display("FAIL reset_rd_data: got %02h, expected 00", uart_rd_data); else passes++;
        checks++; if (uart_wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b, expected 0", uart_wr_ready); else passes++;
        rst = 1'b1;
        #1;
        checks++; if (uart_wr_ready !== 1'b0) $display("FAIL release_wr_ready_early: got %b, expected 0", uart_wr_ready); else passes++;
        @(posedge clk); #1;
        checks++; if (uart_wr_ready !== 1'b1) $display("FAIL release_wr_ready: got %b, expected 1", uart_wr_ready); else passes++;
    endtask

    task automatic test_rx_stream;
        int start_cnt;
        start_cnt = rx_cnt;
        for (int b = 8'h10; b <= 8'h13; b++) begin
            exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1);
        end
        repeat (CPB) @(negedge clk);
        checks++; if (rx_cnt - start_cnt !== 4) $display("FAIL rx_stream_count: got %0d, expected 4", rx_cnt - start_cnt); else passes++;
        checks++; if (exp_q.size() !== 0) $display("FAIL rx_stream_left: got %0d, expected 0", exp_q.size()); else passes++;
    endtask

    task automatic test_tx;
        int   ready_k;
        logic eb;
        ready_k = -1;
        push_tx_bits(8'hA5);
        @(negedge clk);
        uart_wr_data  = 8'hA5;
        uart_wr_valid = 1'b1;
        @(posedge clk); #1;
        uart_wr_valid = 1'b0;
        checks++; if (uart_wr_ready !== 1'b0) $display("FAIL tx_ready_drop: got %b, expected 0", uart_wr_ready); else passes++;
        checks++; if (uart_txd !== 1'b0) $display("FAIL tx_start_bit: got %b, expected 0", uart_txd); else passes++;
        for (int k = 1; k <= 10 * CPB + 2; k++) begin
            @(posedge clk); #1;
            if (ready_k < 0 && uart_wr_ready === 1'b1) ready_k = k;
            if (k == CPB - 1) begin
                checks++; if (uart_txd !== 1'b0) $display("FAIL tx_start_last: got %b, expected 0", uart_txd); else passes++;
            end
            if (k == CPB) begin
                checks++; if (uart_txd !== 1'b1) $display("FAIL tx_bit0_first: got %b, expected 1", uart_txd); else passes++;
            end
            if (k % CPB == CPB / 2 && tx_exp_q.size() != 0) begin
                eb = tx_exp_q.pop_front();
                checks++; if (uart_txd !== eb) $display("FAIL tx_bit%0d: got %b, expected %b", k / CPB, uart_txd, eb); else passes++;
            end
        end
        checks++; if (ready_k !== 10 * CPB) $display("FAIL tx_busy_cycles: got %0d, expected %0d", ready_k, 10 * CPB); else passes++;
        checks++; if (tx_exp_q.size() !== 0) $display("FAIL tx_bits_left: got %0d, expected 0", tx_exp_q.size()); else passes++;
    endtask

    task automatic test_glitch;
        int start_cnt;
        @(negedge clk); #1;
        seen_valid = 1'b0;
        start_cnt  = rx_cnt;
        uart_rxd   = 1'b0;
        repeat (200) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checks++; if (seen_valid !== 1'b0) $display("FAIL glitch_no_byte: got valid %b, expected 0", seen_valid); else passes++;
        checks++; if (rx_cnt !== start_cnt) $display("FAIL glitch_count: got %0d, expected %0d", rx_cnt, start_cnt); else passes++;
    endtask

    task automatic test_frame_error;
        @(negedge clk); #1;
        seen_valid = 1'b0;
        send_frame(8'h33, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        checks++; if (seen_valid !== 1'b0) $display("FAIL framing_no_byte: got valid %b, expected 0", seen_valid); else passes++;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        repeat (CPB) @(negedge clk);
        checks++; if (exp_q.size() !== 0) $display("FAIL framing_recover: got %0d left, expected 0", exp_q.size()); else passes++;
    endtask

    task automatic test_overrun;
        @(posedge clk); #1;
        uart_rd_ready = 1'b0;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        repeat (CPB) @(negedge clk);
        checks++; if (uart_rd_valid !== 1'b1) $display("FAIL overrun_valid: got %b, expected 1", uart_rd_valid); else passes++;
        checks++; if (uart_rd_data !== 8'h55) $display("FAIL overrun_data: got %02h, expected 55", uart_rd_data); else passes++;
        @(posedge clk); #1;
        uart_rd_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (uart_rd_valid !== 1'b0) $display("FAIL overrun_drain: got %b, expected 0", uart_rd_valid); else passes++;
        checks++; if (exp_q.size() !== 0) $display("FAIL overrun_left: got %0d, expected 0", exp_q.size()); else passes++;
    endtask

`ifdef UART_LOOPBACK_EN
    task automatic test_loopback;
        @(posedge clk); #1;
        uart_mode = 2'b01;
        repeat (4) @(negedge clk);
        exp_q.push_back(8'h3C);
        uart_wr_data  = 8'h3C;
        uart_wr_valid = 1'b1;
        @(posedge clk); #1;
        uart_wr_valid = 1'b0;
        for (int k = 0; k < 12 * CPB && exp_q.size() != 0; k++) @(negedge clk);
        checks++; if (exp_q.size() !== 0) $display("FAIL loopback_rx: got %0d left, expected 0", exp_q.size()); else passes++;
        repeat (CPB) @(negedge clk);
        @(posedge clk); #1;
        uart_mode = 2'b00;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_echo;
        logic eb;
        int   k0;
        @(posedge clk); #1;
        uart_mode = 2'b10;
        repeat (4) @(negedge clk);
        checks++; if (uart_wr_ready !== 1'b0) $display("FAIL echo_wr_ready: got %b, expected 0", uart_wr_ready); else passes++;
        #1;
        seen_valid = 1'b0;
        push_tx_bits(8'h7E);
        fork
            send_frame(8'h7E, 1'b1);
            begin
                k0 = 0;
                do begin
                    @(posedge clk); #1;
                    k0++;
                end while (uart_txd !== 1'b0 && k0 < 12 * CPB);
                checks++;
                if (uart_txd !== 1'b0) begin
                    $display("FAIL echo_start: got txd %b after %0d cycles, expected 0", uart_txd, k0);
                end else begin
                    passes++;
                    for (int k = 1; k <= 9 * CPB + CPB / 2; k++) begin
                        @(posedge clk); #1;
                        if (k % CPB == CPB / 2 && tx_exp_q.size() != 0) begin
                            eb = tx_exp_q.pop_front();
                            checks++; if (uart_txd !== eb) $display("FAIL echo_bit%0d: got %b, expected %b", k / CPB, uart_txd, eb); else passes++;
                        end
                    end
                end
            end
        join
        checks++; if (seen_valid !== 1'b0) $display("FAIL echo_rd_valid: got %b, expected 0", seen_valid); else passes++;
        checks++; if (tx_exp_q.size() !== 0) $display("FAIL echo_bits_left: got %0d, expected 0", tx_exp_q.size()); else passes++;
        tx_exp_q.delete();
        repeat (CPB) @(negedge clk);
        @(posedge clk); #1;
        uart_mode = 2'b00;
        repeat (4) @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid_tx;
        int lows;
        lows = 0;
        @(negedge clk);
        uart_wr_data  = 8'hFF;
        uart_wr_valid = 1'b1;
        @(posedge clk); #1;
        uart_wr_valid = 1'b0;
        repeat (5 * CPB + CPB / 2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (uart_txd !== 1'b1) $display("FAIL midreset_txd: got %b, expected 1", uart_txd); else passes++;
        checks++; if (uart_wr_ready !== 1'b0) $display("FAIL midreset_wr_ready: got %b, expected 0", uart_wr_ready); else passes++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (uart_wr_ready !== 1'b1) $display("FAIL midreset_release: got %b, expected 1", uart_wr_ready); else passes++;
        for (int k = 0; k < 2 * CPB; k++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) lows++;
        end
        checks++; if (lows !== 0) $display("FAIL midreset_line_idle: got %0d low cycles, expected 0", lows); else passes++;
    endtask

    initial begin
        test_reset();
        test_rx_stream();
        test_tx();
        test_glitch();
        test_frame_error();
        test_overrun();
`ifdef UART_LOOPBACK_EN
        test_loopback();
        test_echo();
`endif
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_core.md
# uart_core

Full-duplex 8N1 UART with byte-wide valid/ready streams on the fabric side and serial RXD/TXD on the pin side. It runs on one system clock taken from the board clock/reset generator. It converts serial frames to bytes and bytes to serial frames at a fixed baud rate derived from the clock frequency. It also provides an optional internal loopback/echo mode for bring-up.

## Interface
- CLK_FREQ, 100000000: clock frequency in Hz.
- BAUD_RATE, 115200: serial bit rate.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- uart_rd_data  out  8  received byte.
- uart_rd_valid  out  1  received byte available.
- uart_rd_ready  in  1  consumer accepts the byte.
- uart_wr_data  in  8  byte to transmit.
- uart_wr_valid  in  1  byte to transmit is presented.
- uart_wr_ready  out  1  transmitter can accept a byte.
- uart_mode  in  2  mode select: 00 normal, 01 internal loopback, 10 echo, 11 treated as 00.
- uart_rxd  in  1  serial input, idle high, asynchronous to clk.
- uart_txd  out  1  serial output, idle high.

## Operation
- Bit period CLKS_PER_BIT = round(CLK_FREQ/BAUD_RATE). Default is 868. Elaboration fails if the result is below 16.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- RX input: uart_rxd passes through a 2-flop synchronizer that resets to 1.
- RX state machine, IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: leave on a synchronized falling edge.
  - START: re-sample at CLKS_PER_BIT/2. If the line is high, treat it as a glitch and return to IDLE.
  - DATA: sample each bit at its centre, every CLKS_PER_BIT cycles.
  - STOP: sample the stop bit at its centre. A 1 delivers the byte. A 0 is a framing error: discard the byte and return to IDLE only after the line is seen high.
- RX holding register is one deep:
  - A delivered byte loads uart_rd_data and sets uart_rd_valid.
  - uart_rd_valid stays set until uart_rd_valid && uart_rd_ready.
  - Overrun (a new byte completes while uart_rd_valid is still set): the new byte is dropped and the held byte is unchanged.
- TX state machine, IDLE -> START -> DATA -> STOP -> IDLE. Each bit is driven for exactly CLKS_PER_BIT cycles.
- Modes:
  - 01 (loopback): the RX engine takes the internal TX serial stream instead of uart_rxd. uart_txd is still driven.
  - 10 (echo): every byte received from uart_rxd is sent by TX. uart_wr_* is ignored and uart_wr_ready is held 0. Echo bypasses the RX holding register, so uart_rd_valid stays 0.
  - Mode changes take effect only when both engines are in IDLE.

## Timing
- Values while rst is low: uart_rd_data=0, uart_rd_valid=0, uart_wr_ready=0, uart_txd=1. All FSMs in IDLE, all counters 0.
- uart_wr_ready goes to 1 on the first clk edge after reset is released.
- Reset asserted mid-frame aborts immediately: uart_txd returns to 1 and any partial RX byte is lost.
- TX accept happens on uart_wr_valid && uart_wr_ready at a clk edge:
  - uart_wr_ready drops on the same edge.
  - The start bit appears on uart_txd on the next cycle.
  - uart_wr_ready returns high after the full stop bit: 10*CLKS_PER_BIT cycles after the start bit begins. No back-to-back accept without that gap.
- RX latency: uart_rd_valid rises 2 cycles after the stop-bit centre sample (one cycle for the sample, one for the register). Measured from the falling edge of the start bit at the pin, this is about 9.5*CLKS_PER_BIT+4 cycles.
- A read handshake and a newly delivered byte on the same cycle: the new byte loads and uart_rd_valid stays 1.

## Configuration
- UART_LOOPBACK_EN defined: modes 01 and 10 behave as described above.
- UART_LOOPBACK_EN undefined: uart_mode is ignored, the core always runs in normal mode, and the loopback/echo muxes are not generated.

## Structure
- Package uart_pkg holds:
  - mode enum (UART_NORMAL, UART_LOOPBACK, UART_ECHO);
  - RX and TX state enums;
  - the CLKS_PER_BIT computation function;
  - frame constants (8 data bits, 1 stop bit).
- One sub-module, uart_rx_engine: synchronizer, RX FSM and sampling counter, outputting byte plus a one-cycle done/framing-error strobe.
- TX FSM, holding register and mode muxing live in uart_core.

## Test plan
- Reset: hold rst low, then release → txd=1, rd_valid=0, rd_data=0; wr_ready=1 one cycle after release.
- RX stream: drive frames 0x10, 0x11, 0x12, 0x13 at 115200 baud with rd_ready=1 → four rd_valid pulses with those bytes in order.
- TX: write 0xA5 → txd shows 0,1,0,1,0,0,1,0,1,1, each bit 868 cycles; wr_ready low for 8680 cycles.
- Errors:
  - a low pulse of 200 cycles → no byte;
  - stop bit forced 0 → no rd_valid;
  - two frames 0x55, 0xAA with rd_ready=0 → rd_data stays 0x55 (overrun drops 0xAA).
- Mode 01 with UART_LOOPBACK_EN defined: write 0x3C → rd_valid with 0x3C. Mode 10: receive 0x7E → txd retransmits 0x7E and rd_valid stays 0.
- Reset mid-frame during TX of 0xFF: assert rst at bit 4 → txd goes to 1 immediately, wr_ready=0 while in reset, 1 one cycle after release.
